// File: rtl/overlay_pkg.sv
// Shared constants for the video overlay path: coordinate width, pixel
// format width and common RGB888 colours.
package overlay_pkg;

    localparam int unsigned CW_DEF = 11;
    localparam int unsigned RGB_W  = 24;

    localparam logic [RGB_W-1:0] COLOR_RED   = 24'hFF0000;
    localparam logic [RGB_W-1:0] COLOR_BLACK = 24'h000000;

endpackage

// File: rtl/video_pos_cnt.sv
// Pixel position tracker: edge detection on de/vsync plus saturating
// column (x_cnt) and row (y_cnt) counters for the current pixel.
module video_pos_cnt
    import overlay_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          pixelclk,
    input  logic          rst,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [CW-1:0] x_cnt,
    output logic [CW-1:0] y_cnt,
    output logic          vs_rise
);

    logic de_q;
    logic vs_q;
    logic de_fall;

    assign vs_rise = i_vsync & ~vs_q;
    assign de_fall = de_q & ~i_de;

    // Edge-detect history and saturating x/y counters; vsync clear beats row increment.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            de_q <= i_de;
            vs_q <= i_vsync;

            if (i_de) begin
                if (x_cnt != '1)
                    x_cnt <= x_cnt + 1'b1;
            end else begin
                x_cnt <= '0;
            end

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && (y_cnt != '1))
                y_cnt <= y_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/box_overlay.sv
// Draws a rectangular outline of configurable thickness onto the delayed
// RGB stream. Box coordinates are double-buffered and only promoted to the
// active set on a vsync rise, so a box never changes mid-frame.
module box_overlay
    import overlay_pkg::*;
#(
    parameter int unsigned      CW        = CW_DEF,
    parameter int unsigned      THICK     = 2,
    parameter logic [RGB_W-1:0] BOX_COLOR = COLOR_RED
) (
    input  logic             pixelclk,
    input  logic             rst,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [RGB_W-1:0] i_rgb,
    input  logic             box_en,
    input  logic             box_load,
    input  logic [CW-1:0]    box_xmin,
    input  logic [CW-1:0]    box_xmax,
    input  logic [CW-1:0]    box_ymin,
    input  logic [CW-1:0]    box_ymax,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [RGB_W-1:0] o_rgb
);

    localparam logic [CW:0] THICK_W = (CW+1)'(THICK);

    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic          vs_rise;

    logic [CW-1:0] pend_xmin, pend_xmax, pend_ymin, pend_ymax;
    logic [CW-1:0] act_xmin,  act_xmax,  act_ymin,  act_ymax;
    logic          pending_vld;
    logic          active_vld;

    logic          hit;

    video_pos_cnt #(
        .CW (CW)
    ) u_pos (
        .pixelclk (pixelclk),
        .rst      (rst),
        .i_vsync  (i_vsync),
        .i_de     (i_de),
        .x_cnt    (x_cnt),
        .y_cnt    (y_cnt),
        .vs_rise  (vs_rise)
    );

    // Double-buffered box registers: a load landing on the vsync rise goes to
    // pending while the previous pending set is promoted in the same cycle.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            pend_xmin   <= '0;
            pend_xmax   <= '0;
            pend_ymin   <= '0;
            pend_ymax   <= '0;
            act_xmin    <= '0;
            act_xmax    <= '0;
            act_ymin    <= '0;
            act_ymax    <= '0;
            pending_vld <= 1'b0;
            active_vld  <= 1'b0;
        end else begin
            if (vs_rise && pending_vld) begin
                act_xmin    <= pend_xmin;
                act_xmax    <= pend_xmax;
                act_ymin    <= pend_ymin;
                act_ymax    <= pend_ymax;
                active_vld  <= 1'b1;
                pending_vld <= 1'b0;
            end
            if (box_load) begin
                pend_xmin   <= box_xmin;
                pend_xmax   <= box_xmax;
                pend_ymin   <= box_ymin;
                pend_ymax   <= box_ymax;
                pending_vld <= 1'b1;
            end
        end
    end

    // Outline hit: inside the box and within THICK of any edge; sums at CW+1 bits.
    always_comb begin
        logic [CW:0] x_e, y_e;
        logic        in_box;
        logic        near_edge;
        hit       = 1'b0;
        x_e       = {1'b0, x_cnt};
        y_e       = {1'b0, y_cnt};
        in_box    = (x_cnt >= act_xmin) && (x_cnt <= act_xmax) &&
                    (y_cnt >= act_ymin) && (y_cnt <= act_ymax);
        near_edge = (x_e < ({1'b0, act_xmin} + THICK_W)) ||
                    ((x_e + THICK_W) > {1'b0, act_xmax}) ||
                    (y_e < ({1'b0, act_ymin} + THICK_W)) ||
                    ((y_e + THICK_W) > {1'b0, act_ymax});
        hit       = i_de && box_en && active_vld && in_box && near_edge;
    end

    // Single-cycle output register for timing and the (possibly recoloured) pixel.
    always_ff @(posedge pixelclk) begin
        if (rst) begin
            o_vsync <= 1'b0;
            o_hsync <= 1'b0;
            o_de    <= 1'b0;
            o_rgb   <= COLOR_BLACK;
        end else begin
            o_vsync <= i_vsync;
            o_hsync <= i_hsync;
            o_de    <= i_de;
            o_rgb   <= hit ? BOX_COLOR : i_rgb;
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// Scoreboard bench for box_overlay: two instances (THICK=1 and THICK=2)
// share all inputs; expected outputs are queued as stimulus is driven and
// compared one cycle later.
module tb_box_overlay;

    typedef struct packed {
        int xmn;
        int xmx;
        int ymn;
        int ymx;
    } box_t;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [23:0] rgb1;
        logic [23:0] rgb2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vsync, i_hsync, i_de;
    logic [23:0] i_rgb;
    logic        box_en, box_load;
    logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic        o_vsync1, o_hsync1, o_de1;
    logic        o_vsync2, o_hsync2, o_de2;
    logic [23:0] o_rgb1, o_rgb2;

    int n_chk = 0;
    int n_bad = 0;

    exp_t sb[$];

    // frame-level stimulus state
    int   f_num = 0;
    int   f_c = 0;
    bit   f_en = 0;
    bit   f_vld = 0;
    box_t f_box = '0;
    int   f_ld_cyc = -1;
    box_t f_nb = '0;
    int   f_rst_cyc = -1;
    bit   force_rst = 0;

    always #5 clk = ~clk;

    box_overlay #(.CW(11), .THICK(1), .BOX_COLOR(24'hFF0000)) u_dut1 (
        .pixelclk (clk),      .rst      (rst),
        .i_vsync  (i_vsync),  .i_hsync  (i_hsync),
        .i_de     (i_de),     .i_rgb    (i_rgb),
        .box_en   (box_en),   .box_load (box_load),
        .box_xmin (box_xmin), .box_xmax (box_xmax),
        .box_ymin (box_ymin), .box_ymax (box_ymax),
        .o_vsync  (o_vsync1), .o_hsync  (o_hsync1),
        .o_de     (o_de1),    .o_rgb    (o_rgb1)
    );

    box_overlay #(.CW(11), .THICK(2), .BOX_COLOR(24'hFF0000)) u_dut2 (
        .pixelclk (clk),      .rst      (rst),
        .i_vsync  (i_vsync),  .i_hsync  (i_hsync),
        .i_de     (i_de),     .i_rgb    (i_rgb),
        .box_en   (box_en),   .box_load (box_load),
        .box_xmin (box_xmin), .box_xmax (box_xmax),
        .box_ymin (box_ymin), .box_ymax (box_ymax),
        .o_vsync  (o_vsync2), .o_hsync  (o_hsync2),
        .o_de     (o_de2),    .o_rgb    (o_rgb2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d cyc=%0d got=%h exp=%h", tag, f_num, f_c, obs, exp);
        end
    endtask

    // Outline = inside the box but not inside the box shrunk by t on every side.
    function automatic logic [23:0] model_rgb(input int x, input int y, input bit de,
                                              input bit en, input bit vld, input box_t b,
                                              input int t, input logic [23:0] rgb);
        bit inb, inner;
        if (!(de && en && vld))
            return rgb;
        inb   = (x >= b.xmn) && (x <= b.xmx) && (y >= b.ymn) && (y <= b.ymx);
        inner = (x >= b.xmn + t) && (x <= b.xmx - t) && (y >= b.ymn + t) && (y <= b.ymx - t);
        return (inb && !inner) ? 24'hFF0000 : rgb;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("vsync1", 32'(o_vsync1), 32'(e.vs));
            chk("hsync1", 32'(o_hsync1), 32'(e.hs));
            chk("de1",    32'(o_de1),    32'(e.de));
            chk("vsync2", 32'(o_vsync2), 32'(e.vs));
            chk("rgb_t1", 32'(o_rgb1),   32'(e.rgb1));
            chk("rgb_t2", 32'(o_rgb2),   32'(e.rgb2));
        end
    endtask

    task automatic step(input bit vs, input bit hs, input bit de, input int x, input int y);
        logic [23:0] px;
        bit ld, r;
        exp_t e;
        px = de ? {8'(f_num * 16 + y), 8'(x * 8), 8'hA5 ^ 8'(x)} : 24'($urandom);
        ld = (f_c == f_ld_cyc);
        r  = force_rst || (f_c == f_rst_cyc);
        @(negedge clk);
        pop_check();
        rst      = r;
        i_vsync  = vs;
        i_hsync  = hs;
        i_de     = de;
        i_rgb    = px;
        box_en   = f_en;
        box_load = ld;
        box_xmin = ld ? 11'(f_nb.xmn) : 11'($urandom);
        box_xmax = ld ? 11'(f_nb.xmx) : 11'($urandom);
        box_ymin = ld ? 11'(f_nb.ymn) : 11'($urandom);
        box_ymax = ld ? 11'(f_nb.ymx) : 11'($urandom);
        if (r) begin
            e = '0;
        end else begin
            e.vs   = vs;
            e.hs   = hs;
            e.de   = de;
            e.rgb1 = model_rgb(x, y, de, f_en, f_vld, f_box, 1, px);
            e.rgb2 = model_rgb(x, y, de, f_en, f_vld, f_box, 2, px);
        end
        sb.push_back(e);
        if (r)
            f_vld = 0;
        f_c++;
    endtask

    // 8x6 frame: 2 vsync cycles, 1 blank, then rows of hsync, blank, 8 pixels, 2 blank.
    task automatic frame(input bit en, input bit vld, input box_t b,
                         input int ld_cyc, input box_t nb, input int rst_cyc);
        f_num++;
        f_c       = 0;
        f_en      = en;
        f_vld     = vld;
        f_box     = b;
        f_ld_cyc  = ld_cyc;
        f_nb      = nb;
        f_rst_cyc = rst_cyc;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            step(0, 1, 0, 0, r);
            step(0, 0, 0, 0, r);
            for (int c = 0; c < 8; c++)
                step(0, 0, 1, c, r);
            step(0, 0, 0, 0, r);
            step(0, 0, 0, 0, r);
        end
    endtask

    initial begin
        box_t bz, ba, bb, bc, bd, be, bg, bf;
        bz = '{0, 0, 0, 0};
        ba = '{2, 5, 1, 4};
        bb = '{1, 6, 0, 5};
        bc = '{0, 3, 2, 5};
        bd = '{6, 3, 0, 5};
        be = '{2, 4, 1, 4};
        bg = '{0, 7, 0, 5};
        bf = '{1, 2, 1, 2};

        // initial reset: outputs must read zero
        force_rst = 1;
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0);
        force_rst = 0;

        // pass-through with overlay disabled; box A loaded mid-frame
        frame(0, 0, bz, 5, ba, -1);
        // box A active; box B loaded mid-frame must not show yet
        frame(1, 1, ba, 20, bb, -1);
        // box B active; box C left pending
        frame(1, 1, bb, 30, bc, -1);
        // degenerate D loaded on the vsync rise; pending C applies now
        frame(1, 1, bc, 0, bd, -1);
        // degenerate D active: nothing recoloured; narrow E loaded
        frame(1, 1, bd, 40, be, -1);
        // width-3 box: THICK=2 instance fully filled
        frame(1, 1, be, -1, bz, -1);
        // box_en low with a valid active box
        frame(0, 1, be, -1, bz, -1);
        // G loaded, then reset mid-row clears active and pending
        frame(1, 1, be, 3, bg, 40);
        // overlay must stay off; F loaded mid-frame
        frame(1, 0, bz, 30, bf, -1);
        // F takes effect after the vsync rise
        frame(1, 1, bf, -1, bz, -1);

        @(negedge clk);
        pop_check();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
